// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: FSM states,
// opcodes, ALU operation codes, datapath select codes and the strobe bundle.
package mips_ctrl_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMRD    = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWR    = 4'd5;
    localparam logic [3:0] ST_RTYPE_EX = 4'd6;
    localparam logic [3:0] ST_ALUWB    = 4'd7;
    localparam logic [3:0] ST_BRANCH   = 4'd8;
    localparam logic [3:0] ST_IMM_EX   = 4'd9;
    localparam logic [3:0] ST_IMMWB    = 4'd10;
    localparam logic [3:0] ST_JUMP     = 4'd11;
    localparam logic [3:0] ST_JAL      = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;
    localparam logic [3:0] ALU_LUI   = 4'b0011;
    localparam logic [3:0] ALU_SLT   = 4'b0100;
    localparam logic [3:0] ALU_AND   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_XOR   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       jal;
        logic       ui;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/imm_aluop_decode.sv
// Maps a latched immediate-class opcode to its ALU operation and the
// zero-extend flag for the immediate.
module imm_aluop_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    output logic [3:0] alu_op_o,
    output logic       ui_o
);

    // Opcode to {ALUOp, ui}; non-immediate opcodes fall back to add/sign-extend
    always_comb begin
        alu_op_o = ALU_ADD;
        ui_o     = 1'b0;
        case (op_i)
            OP_LUI:   begin alu_op_o = ALU_LUI;  ui_o = 1'b0; end
            OP_ADDIU: begin alu_op_o = ALU_ADD;  ui_o = 1'b1; end
            OP_ANDI:  begin alu_op_o = ALU_AND;  ui_o = 1'b1; end
            OP_ORI:   begin alu_op_o = ALU_OR;   ui_o = 1'b1; end
            OP_XORI:  begin alu_op_o = ALU_XOR;  ui_o = 1'b1; end
            OP_SLTI:  begin alu_op_o = ALU_SLT;  ui_o = 1'b0; end
            OP_SLTIU: begin alu_op_o = ALU_SLTU; ui_o = 1'b1; end
            default:  begin alu_op_o = ALU_ADD;  ui_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multi-cycle MIPS-subset datapath, sharing one
// memory port between fetch and data access and stalling on mem_ready.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               jal,
    output logic               ui,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSrc,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [5:0]         op_q, op_d;
    ctrl_t              ctrl_s, ctrl_out_s;
    logic [3:0]         imm_alu_op_s;
    logic               imm_ui_s;

    imm_aluop_decode u_imm_aluop_decode (
        .op_i     (op_q),
        .alu_op_o (imm_alu_op_s),
        .ui_o     (imm_ui_s)
    );

    // Next-state and per-state strobe decode
    always_comb begin
        ctrl_s  = '0;
        state_d = ST_FETCH;
        op_d    = op_q;
        case (state_q)
            ST_FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.alu_src_b = SRCB_FOUR;
                ctrl_s.alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ctrl_s.ir_write = 1'b1;
                    ctrl_s.pc_en    = 1'b1;
                    ctrl_s.pc_src   = PCSRC_ALU;
                    state_d         = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // Speculatively compute the branch target while the opcode settles
                ctrl_s.alu_src_b = SRCB_IMM_SH2;
                op_d             = opcode;
                case (opcode)
                    OP_LW, OP_SW:   state_d = ST_MEMADR;
                    OP_RTYPE:       state_d = ST_RTYPE_EX;
                    OP_BEQ, OP_BNE: state_d = ST_BRANCH;
                    OP_LUI, OP_ADDIU, OP_ANDI, OP_ORI,
                    OP_XORI, OP_SLTI, OP_SLTIU: state_d = ST_IMM_EX;
                    OP_J:           state_d = ST_JUMP;
                    OP_JAL:         state_d = ST_JAL;
                    default: begin
                        ctrl_s.illegal = 1'b1;
                        state_d        = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
                if (op_q == OP_LW) begin
                    state_d = ST_MEMRD;
                end else begin
                    state_d = ST_MEMWR;
                end
            end
            ST_MEMRD: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.iord     = 1'b1;
                if (mem_ready) begin
                    state_d = ST_MEMWB;
                end else begin
                    state_d = ST_MEMRD;
                end
            end
            ST_MEMWB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.iord      = 1'b1;
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_MEMWR;
                end
            end
            ST_RTYPE_EX: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_RT;
                ctrl_s.alu_op    = ALU_FUNCT;
                state_d          = ST_ALUWB;
            end
            ST_ALUWB: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_RT;
                ctrl_s.alu_op    = ALU_SUB;
                ctrl_s.pc_src    = PCSRC_ALUOUT;
                if (op_q == OP_BNE) begin
                    ctrl_s.pc_en = ~zero;
                end else begin
                    ctrl_s.pc_en = zero;
                end
            end
            ST_IMM_EX: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_op    = imm_alu_op_s;
                ctrl_s.ui        = imm_ui_s;
                state_d          = ST_IMMWB;
            end
            ST_IMMWB: begin
                // ALUOp/ui stay valid so the ALU result is stable during writeback
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_op    = imm_alu_op_s;
                ctrl_s.ui        = imm_ui_s;
            end
            ST_JUMP: begin
                ctrl_s.pc_en  = 1'b1;
                ctrl_s.pc_src = PCSRC_JUMP;
            end
            ST_JAL: begin
                ctrl_s.pc_en     = 1'b1;
                ctrl_s.pc_src    = PCSRC_JUMP;
                ctrl_s.reg_write = 1'b1;
                ctrl_s.jal       = 1'b1;
            end
            default: begin
                ctrl_s  = '0;
                state_d = ST_FETCH;
            end
        endcase
    end

    // Reset masks every strobe so an abandoned instruction issues no write
    always_comb begin
        if (reset) begin
            ctrl_out_s = '0;
        end else begin
            ctrl_out_s = ctrl_s;
        end
    end

    // State and latched opcode registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            op_q    <= 6'b000000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign pc_en    = ctrl_out_s.pc_en;
    assign IorD     = ctrl_out_s.iord;
    assign MemRead  = ctrl_out_s.mem_read;
    assign MemWrite = ctrl_out_s.mem_write;
    assign IRWrite  = ctrl_out_s.ir_write;
    assign MemtoReg = ctrl_out_s.mem_to_reg;
    assign RegDst   = ctrl_out_s.reg_dst;
    assign RegWrite = ctrl_out_s.reg_write;
    assign jal      = ctrl_out_s.jal;
    assign ui       = ctrl_out_s.ui;
    assign ALUSrcA  = ctrl_out_s.alu_src_a;
    assign ALUSrcB  = ctrl_out_s.alu_src_b;
    assign ALUOp    = ctrl_out_s.alu_op;
    assign PCSrc    = ctrl_out_s.pc_src;
    assign illegal  = ctrl_out_s.illegal;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: an instruction-level model expands each
// opcode into its expected per-cycle state/strobe trace and drives mem_ready.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst;
    logic       RegWrite, jal, ui, ALUSrcA, illegal;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] ALUOp;
    logic [3:0] state;

    int tests_run    = 0;
    int tests_failed = 0;

    multicycle_control #(.STATE_W(4), .ALUOP_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .jal(jal), .ui(ui), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en, iord, mrd, mwr, irw, m2r, rdst, rw, jal, ui, srca;
        logic [1:0] srcb;
        logic [3:0] aluop;
        logic [1:0] pcsrc;
        logic       ill;
    } obs_t;

    localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BR = 3, C_IMM = 4, C_J = 5, C_JAL = 6, C_ILL = 7;

    obs_t       exp_q[$];
    logic       rdy_q[$];
    logic       zq[$];
    logic [5:0] oq[$];

    logic [5:0] legal_ops [14] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                   6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101,
                                   6'b001110, 6'b001111, 6'b000010, 6'b000011};

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.pc_en = pc_en; o.iord = IorD; o.mrd = MemRead; o.mwr = MemWrite;
        o.irw = IRWrite; o.m2r = MemtoReg; o.rdst = RegDst; o.rw = RegWrite; o.jal = jal;
        o.ui = ui; o.srca = ALUSrcA; o.srcb = ALUSrcB; o.aluop = ALUOp; o.pcsrc = PCSrc;
        o.ill = illegal;
        return o;
    endfunction

    function automatic obs_t blank(input int st);
        obs_t o = '0;
        o.st = st[3:0];
        return o;
    endfunction

    function automatic int classify(input logic [5:0] op);
        case (op)
            6'b000000: return C_R;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100, 6'b000101: return C_BR;
            6'b001001, 6'b001010, 6'b001011, 6'b001100,
            6'b001101, 6'b001110, 6'b001111: return C_IMM;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            default:   return C_ILL;
        endcase
    endfunction

    // {ALUOp, ui} for immediate-class instructions
    function automatic logic [4:0] imm_code(input logic [5:0] op);
        case (op)
            6'b001111: return 5'b0011_0;
            6'b001001: return 5'b0000_1;
            6'b001100: return 5'b0101_1;
            6'b001101: return 5'b0110_1;
            6'b001110: return 5'b0111_1;
            6'b001010: return 5'b0100_0;
            6'b001011: return 5'b1001_1;
            default:   return 5'b0000_0;
        endcase
    endfunction

    task automatic push(input obs_t o, input logic rdy, input logic z, input logic [5:0] op);
        exp_q.push_back(o); rdy_q.push_back(rdy); zq.push_back(z); oq.push_back(op);
    endtask

    // Expand one instruction into its expected cycle trace and per-cycle inputs
    task automatic build(input logic [5:0] op, input logic z, input int fs, input int ms);
        obs_t o;
        int   k;
        logic [4:0] ic;
        for (int i = 0; i <= fs; i++) begin
            o = blank(0); o.mrd = 1'b1; o.srcb = 2'b01;
            if (i == fs) begin o.irw = 1'b1; o.pc_en = 1'b1; end
            push(o, (i == fs), 1'($urandom), 6'($urandom));
        end
        k = classify(op);
        o = blank(1); o.srcb = 2'b11; o.ill = (k == C_ILL);
        push(o, 1'($urandom), 1'($urandom), op);
        case (k)
            C_R: begin
                o = blank(6); o.srca = 1'b1; o.aluop = 4'b0010;
                push(o, 1'($urandom), 1'($urandom), op);
                o = blank(7); o.rw = 1'b1; o.rdst = 1'b1;
                push(o, 1'($urandom), 1'($urandom), op);
            end
            C_LW, C_SW: begin
                o = blank(2); o.srca = 1'b1; o.srcb = 2'b10;
                push(o, 1'($urandom), 1'($urandom), op);
                for (int i = 0; i <= ms; i++) begin
                    o = blank((k == C_LW) ? 3 : 5); o.iord = 1'b1;
                    if (k == C_LW) o.mrd = 1'b1; else o.mwr = 1'b1;
                    push(o, (i == ms), 1'($urandom), op);
                end
                if (k == C_LW) begin
                    o = blank(4); o.rw = 1'b1; o.m2r = 1'b1;
                    push(o, 1'($urandom), 1'($urandom), op);
                end
            end
            C_BR: begin
                o = blank(8); o.srca = 1'b1; o.aluop = 4'b0001; o.pcsrc = 2'b01;
                o.pc_en = (op == 6'b000100) ? z : ~z;
                push(o, 1'($urandom), z, op);
            end
            C_IMM: begin
                ic = imm_code(op);
                o = blank(9); o.srca = 1'b1; o.srcb = 2'b10; o.aluop = ic[4:1]; o.ui = ic[0];
                push(o, 1'($urandom), 1'($urandom), op);
                o = blank(10); o.rw = 1'b1; o.aluop = ic[4:1]; o.ui = ic[0];
                push(o, 1'($urandom), 1'($urandom), op);
            end
            C_J: begin
                o = blank(11); o.pc_en = 1'b1; o.pcsrc = 2'b10;
                push(o, 1'($urandom), 1'($urandom), op);
            end
            C_JAL: begin
                o = blank(12); o.pc_en = 1'b1; o.pcsrc = 2'b10; o.rw = 1'b1; o.jal = 1'b1;
                push(o, 1'($urandom), 1'($urandom), op);
            end
            default: ;
        endcase
    endtask

    // Play queued cycles (at most max_n) starting just after a rising edge
    task automatic execute(input int max_n, input string name);
        obs_t e, a;
        int   n = 0;
        while (exp_q.size() > 0 && n < max_n) begin
            e = exp_q.pop_front();
            #1;
            mem_ready = rdy_q.pop_front();
            zero      = zq.pop_front();
            opcode    = oq.pop_front();
            #1;
            a = sample();
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL %s cycle %0d: got state=%0d vec=%h, expected state=%0d vec=%h",
                         name, n, a.st, a, e.st, e);
            end
            @(posedge clk);
            n++;
        end
        exp_q.delete(); rdy_q.delete(); zq.delete(); oq.delete();
    endtask

    task automatic test_reset();
        obs_t a;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #2;
            a = sample(); a.st = 4'd0; tests_run++;
            if (a !== '0) begin
                tests_failed++;
                $display("FAIL reset_strobes: got %h, expected 0", a);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0;
        #1; tests_run++;
        if (state !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d, expected 0", state);
        end
        @(posedge clk);
    endtask

    task automatic test_rtype();
        build(6'b000000, 1'b0, 0, 0);
        execute(1000, "rtype");
    endtask

    task automatic test_lw_stall();
        build(6'b100011, 1'b0, 0, 2);
        execute(1000, "lw_stall");
        build(6'b101011, 1'b1, 2, 1);
        execute(1000, "sw_stall");
    endtask

    task automatic test_branch();
        build(6'b000100, 1'b1, 0, 0); execute(1000, "beq_taken");
        build(6'b000100, 1'b0, 0, 0); execute(1000, "beq_not_taken");
        build(6'b000101, 1'b1, 0, 0); execute(1000, "bne_not_taken");
        build(6'b000101, 1'b0, 1, 0); execute(1000, "bne_taken");
    endtask

    task automatic test_imm();
        for (int i = 5; i < 12; i++) begin
            build(legal_ops[i], 1'b0, 0, 0);
            execute(1000, "imm_op");
        end
    endtask

    task automatic test_jump();
        build(6'b000011, 1'b0, 0, 0); execute(1000, "jal");
        build(6'b000010, 1'b1, 0, 0); execute(1000, "j");
    endtask

    task automatic test_illegal();
        build(6'b111111, 1'b0, 0, 0);
        build(6'b000010, 1'b0, 0, 0);
        execute(1000, "illegal");
    endtask

    task automatic test_reset_mid_memwr();
        obs_t a;
        build(6'b101011, 1'b0, 0, 10);
        execute(6, "memwr_prefix");
        #1; reset = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            a = sample(); a.st = 4'd0; tests_run++;
            if (a !== '0 || MemWrite !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mid_memwr cycle %0d: got %h, expected 0", i, a);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1; tests_run++;
        if (state !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_release_state: got %0d, expected 0", state);
        end
        @(posedge clk);
    endtask

    task automatic test_back_to_back();
        logic [5:0] op;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 7) == 0) op = 6'($urandom);
                else op = legal_ops[$urandom_range(0, 13)];
                build(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
            end
            execute(1000, "back_to_back");
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 6'b000000;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_branch();
        test_imm();
        test_jump();
        test_illegal();
        test_reset_mid_memwr();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Sequencing controller for the multi-cycle variant of the MIPS-subset datapath. It replaces the single-cycle opcode decoder with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. It shares one unified memory port between instruction fetch and data access. It stalls on a memory-ready handshake. The block sits between the IR opcode field, the ALU zero flag, the memory ready line and all datapath mux and enable strobes.

Parameters:
- STATE_W, 4, width of the state register and the debug state output.
- ALUOP_W, 4, width of the ALUOp bus; encodings match the existing ALU.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; valid from the DECODE state onward.
- zero  in  1  ALU zero flag, same cycle.
- mem_ready  in  1  memory completed the current read or write this cycle.
- pc_en  out  1  PC load enable (unconditional write, or branch taken).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  writeback select: 1 = MDR.
- RegDst  out  1  destination select: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write.
- jal  out  1  write PC+4 into $31.
- ui  out  1  zero-extend the immediate (instead of sign-extend).
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = 4, 10 = immediate, 11 = immediate<<2.
- ALUOp  out  ALUOP_W  ALU operation code.
- PCSrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded.
- state  out  STATE_W  current state, for debug.

Behaviour:
- Outputs are a Moore decode of the state, plus the latched opcode, zero and mem_ready where noted.
- While reset=1, every strobe and enable output is forced to 0. On the edge where reset=1, state becomes FETCH. A reset in the middle of an instruction abandons it; no partial write is issued after reset.
- Default output values in every state are all 0. The states below list only the outputs that differ.
- FETCH
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0000.
  - While mem_ready=0: stay in FETCH with strobes held.
  - When mem_ready=1: IRWrite=1 and pc_en=1 (PCSrc=00, PC+4); go to DECODE.
- DECODE
  - ALUSrcA=0, ALUSrcB=11, ALUOp=0000 (branch target into ALUOut).
  - Latch opcode into op_q.
  - Next state: lw/sw→MEMADR; R-type (000000)→RTYPE_EX; beq/bne→BRANCH; lui/addiu/andi/ori/xori/slti/sltiu→IMM_EX; j→JUMP; jal→JAL.
  - Any other opcode: illegal=1, go to FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=0000. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next: FETCH.
- MEMWR: MemWrite=1, IorD=1, held until mem_ready. Then FETCH.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=0010. Next: ALUWB.
- ALUWB: RegWrite=1, RegDst=1. Next: FETCH.
- IMM_EX
  - ALUSrcA=1, ALUSrcB=10.
  - ALUOp and ui by opcode: lui 0011/0, addiu 0000/1, andi 0101/1, ori 0110/1, xori 0111/1, slti 0100/0, sltiu 1001/1.
  - Next: IMMWB, with the same ALUOp and ui held.
- IMMWB: RegWrite=1, RegDst=0. Next: FETCH.
- BRANCH
  - ALUSrcA=1, ALUSrcB=00, ALUOp=0001, PCSrc=01.
  - pc_en = zero for beq, and ~zero for bne.
  - Next: FETCH.
- JUMP: pc_en=1, PCSrc=10. Next: FETCH.
- JAL: pc_en=1, PCSrc=10, RegWrite=1, jal=1. Next: FETCH.
- Cycle counts at zero memory wait:
  - R-type, immediate ops and sw: 4 cycles.
  - lw: 5 cycles.
  - Branch, j and jal: 3 cycles.
  - Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- MemRead and MemWrite are never asserted together.
- Unused state encodings go to FETCH on the next edge with all strobes 0.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings (FETCH=0 … JAL=12);
  - opcode constants;
  - ALUOp encodings;
  - ALUSrcB and PCSrc select codes.
- One combinational sub-module, imm_aluop_decode: op_q→{ALUOp, ui}. Used by IMM_EX and IMMWB.

Test Plan:
- Reset held 3 cycles mid-MEMWR, then released: MemWrite=0 during reset; state=0 on the first cycle after release.
- R-type (opcode 000000), mem_ready tied to 1: states 0,1,6,7,0. RegWrite=1 with RegDst=1 only in state 7. ALUOp=0010 in state 6.
- lw (100011), mem_ready low for 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0. MemRead and IorD held through the stall. MemtoReg and RegWrite set in state 4.
- beq (000100): zero=1 gives pc_en=1 with PCSrc=01 in state 8. zero=0 gives pc_en=0. bne (000101) gives the inverse.
- ori (001101): ALUOp=0110 and ui=1 in states 9 and 10. jal (000011): pc_en, RegWrite and jal all 1 in state 12.
- Opcode 111111: illegal pulses for exactly one cycle in DECODE. Next state is FETCH. No RegWrite, MemWrite or pc_en is asserted.
